// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the 4-channel TDM demultiplexer.
// Optional parity checking is enabled with TDM_DEMUX_PARITY_EN.
package tdm_demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  typedef enum logic [1:0] {
    HUNT   = ST_HUNT,
    SYNC   = ST_SYNC,
    ACTIVE = ST_ACTIVE
  } state_t;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_frame_buf.sv
// One-entry valid/ready register slice holding a completed frame.
// A load into a full, non-draining slot is dropped and reported as overflow.
module tdm_frame_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data_out,
  output logic          overflow
);

  logic accept;

  // A slot that drains this cycle can take a new frame with no bubble.
  assign accept = load & (~valid | ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      data_out <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= load & valid & ~ready;
      if (accept) begin
        valid    <= 1'b1;
        data_out <= data_in;
      end else if (valid & ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdm_demux_4ch.sv
// Demultiplexes a 4-slot TDM word stream into one wide frame word with valid/ready.
// Defining TDM_DEMUX_PARITY_EN adds in_par / frame_par_err even-parity checking.
module tdm_demux_4ch
  import tdm_demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  input  logic              in_sof,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic              in_par,
  output logic              frame_par_err,
`endif
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [NUM_CH*W-1:0] frame_data,
  output logic              sync_err,
  output logic              overflow
);

  localparam int FW = NUM_CH * W;

  state_t       state, next_state;
  slot_t        slot, next_slot;
  logic [W-1:0] staging [0:2];
  logic         stage_we;
  slot_t        stage_idx;
  logic         err_next;
  logic         frame_done;

  always_comb begin
    next_state = state;
    next_slot  = slot;
    stage_we   = 1'b0;
    stage_idx  = slot;
    err_next   = 1'b0;
    frame_done = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT, SYNC: begin
          if (in_sof) begin
            stage_we   = 1'b1;
            stage_idx  = 2'd0;
            next_slot  = 2'd1;
            next_state = ACTIVE;
          end else if (state == SYNC) begin
            err_next   = 1'b1;
            next_state = HUNT;
          end
        end
        ACTIVE: begin
          // A premature sof restarts the frame with this word as slot 0.
          if (in_sof) begin
            err_next  = 1'b1;
            stage_we  = 1'b1;
            stage_idx = 2'd0;
            next_slot = 2'd1;
          end else if (slot == 2'd3) begin
            frame_done = 1'b1;
            next_slot  = 2'd0;
            next_state = SYNC;
          end else begin
            stage_we  = 1'b1;
            next_slot = slot + 2'd1;
          end
        end
        default: begin
          next_state = HUNT;
          next_slot  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot     <= 2'd0;
      sync_err <= 1'b0;
    end else begin
      state    <= next_state;
      slot     <= next_slot;
      sync_err <= err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging[0] <= '0;
      staging[1] <= '0;
      staging[2] <= '0;
    end else if (stage_we) begin
      case (stage_idx)
        2'd0:    staging[0] <= in_data;
        2'd1:    staging[1] <= in_data;
        2'd2:    staging[2] <= in_data;
        default: ;
      endcase
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic          par_acc;
  logic          par_bad;
  logic [FW:0]   buf_out;

  assign par_bad = (^in_data) != in_par;

  // Slot 0 restarts accumulation, so discarded partial frames leave no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
    end else if (stage_we) begin
      par_acc <= (stage_idx == 2'd0) ? par_bad : (par_acc | par_bad);
    end else if (frame_done) begin
      par_acc <= 1'b0;
    end
  end

  tdm_frame_buf #(.DW(FW + 1)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (frame_done),
    .data_in  ({par_acc | par_bad, in_data, staging[2], staging[1], staging[0]}),
    .ready    (frame_ready),
    .valid    (frame_valid),
    .data_out (buf_out),
    .overflow (overflow)
  );

  assign frame_data    = buf_out[FW-1:0];
  assign frame_par_err = buf_out[FW];
`else
  tdm_frame_buf #(.DW(FW)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (frame_done),
    .data_in  ({in_data, staging[2], staging[1], staging[0]}),
    .ready    (frame_ready),
    .valid    (frame_valid),
    .data_out (frame_data),
    .overflow (overflow)
  );
`endif

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed self-checking bench for tdm_demux_4ch (W=8).
// Parity scenario runs only when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_4ch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_par = 1'b0;
  logic        frame_valid;
  logic        frame_ready = 1'b1;
  logic [31:0] frame_data;
  logic        sync_err;
  logic        overflow;
`ifdef TDM_DEMUX_PARITY_EN
  logic        frame_par_err;
`endif

  int total = 0;
  int bad = 0;
  int sync_cnt = 0;
  int ovf_cnt = 0;

  always #5 clk = ~clk;

  tdm_demux_4ch #(.W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_sof      (in_sof),
`ifdef TDM_DEMUX_PARITY_EN
    .in_par      (in_par),
    .frame_par_err (frame_par_err),
`endif
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .sync_err    (sync_err),
    .overflow    (overflow)
  );

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sync_err) sync_cnt++;
    if (overflow) ovf_cnt++;
  end

  // Present one word for exactly one clock edge; returns 1 ns after that edge.
  task automatic send(input logic [7:0] d, input logic sof, input logic par_flip);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    in_par   = (^d) ^ par_flip;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (frame_valid !== 1'b0 || frame_data !== 32'h0 || sync_err !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%h se=%b ov=%b expected all 0",
               frame_valid, frame_data, sync_err, overflow);
    end
    do_reset();
  endtask

  task automatic test_basic_frame();
    frame_ready = 1'b1;
    sync_cnt = 0;
    ovf_cnt = 0;
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_valid got %b expected 0", frame_valid);
    end
    send(8'h44, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'h44332211) begin
      bad++;
      $display("FAIL basic_frame got v=%b d=%h expected v=1 d=44332211", frame_valid, frame_data);
    end
    tick();
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain got v=%b expected 0", frame_valid);
    end
    total++;
    if (sync_cnt !== 0 || ovf_cnt !== 0) begin
      bad++;
      $display("FAIL basic_pulses got sync=%0d ovf=%0d expected 0 0", sync_cnt, ovf_cnt);
    end
  endtask

  task automatic test_hunt_drop();
    do_reset();
    sync_cnt = 0;
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'h04030201) begin
      bad++;
      $display("FAIL hunt_frame got v=%b d=%h expected v=1 d=04030201", frame_valid, frame_data);
    end
    tick();
    total++;
    if (sync_cnt !== 0) begin
      bad++;
      $display("FAIL hunt_no_sync_err got %0d pulses expected 0", sync_cnt);
    end
  endtask

  task automatic test_premature_sof();
    sync_cnt = 0;
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h10, 1'b1, 1'b0);
    total++;
    if (sync_err !== 1'b1) begin
      bad++;
      $display("FAIL premature_sync_err got %b expected 1", sync_err);
    end
    send(8'h20, 1'b0, 1'b0);
    send(8'h30, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin
      bad++;
      $display("FAIL premature_partial got v=%b se=%b expected 0 0", frame_valid, sync_err);
    end
    send(8'h40, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'h40302010) begin
      bad++;
      $display("FAIL premature_frame got v=%b d=%h expected v=1 d=40302010", frame_valid, frame_data);
    end
    tick();
    total++;
    if (sync_cnt !== 1) begin
      bad++;
      $display("FAIL premature_count got %0d pulses expected 1", sync_cnt);
    end
  endtask

  task automatic test_back_to_back();
    frame_ready = 1'b0;
    ovf_cnt = 0;
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    send(8'h05, 1'b1, 1'b0);
    send(8'h06, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    total++;
    if (overflow !== 1'b0 || frame_data !== 32'h04030201) begin
      bad++;
      $display("FAIL b2b_hold got ov=%b d=%h expected ov=0 d=04030201", overflow, frame_data);
    end
    send(8'h08, 1'b0, 1'b0);
    total++;
    if (overflow !== 1'b1 || frame_valid !== 1'b1 || frame_data !== 32'h04030201) begin
      bad++;
      $display("FAIL b2b_overflow got ov=%b v=%b d=%h expected ov=1 v=1 d=04030201",
               overflow, frame_valid, frame_data);
    end
    tick();
    total++;
    if (overflow !== 1'b0 || ovf_cnt !== 1) begin
      bad++;
      $display("FAIL b2b_pulse_width got ov=%b cnt=%0d expected 0 1", overflow, ovf_cnt);
    end
    frame_ready = 1'b1;
    tick();
    total++;
    if (frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_transfer got v=%b expected 0", frame_valid);
    end
  endtask

  task automatic test_sync_loss();
    frame_ready = 1'b1;
    sync_cnt = 0;
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    total++;
    if (sync_err !== 1'b1) begin
      bad++;
      $display("FAIL sync_loss_err got %b expected 1", sync_err);
    end
    send(8'h66, 1'b0, 1'b0);
    send(8'hA1, 1'b1, 1'b0);
    send(8'hB2, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0);
    send(8'hD4, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'hD4C3B2A1) begin
      bad++;
      $display("FAIL sync_loss_frame got v=%b d=%h expected v=1 d=D4C3B2A1", frame_valid, frame_data);
    end
    tick();
    total++;
    if (sync_cnt !== 1) begin
      bad++;
      $display("FAIL sync_loss_count got %0d pulses expected 1", sync_cnt);
    end
  endtask

  task automatic test_async_reset();
    send(8'h01, 1'b1, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (frame_valid !== 1'b0 || frame_data !== 32'h0 || sync_err !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got v=%b d=%h se=%b ov=%b expected all 0",
               frame_valid, frame_data, sync_err, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Idle gaps between words must not disturb slot tracking.
    send(8'h0A, 1'b0, 1'b0);
    send(8'h0A, 1'b1, 1'b0);
    tick();
    send(8'h0B, 1'b0, 1'b0);
    tick();
    tick();
    send(8'h0C, 1'b0, 1'b0);
    send(8'h0D, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'h0D0C0B0A) begin
      bad++;
      $display("FAIL gap_frame got v=%b d=%h expected v=1 d=0D0C0B0A", frame_valid, frame_data);
    end
    tick();
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    frame_ready = 1'b1;
    send(8'h31, 1'b1, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b1);
    send(8'h34, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'h34333231 || frame_par_err !== 1'b1) begin
      bad++;
      $display("FAIL parity_bad got v=%b d=%h pe=%b expected v=1 d=34333231 pe=1",
               frame_valid, frame_data, frame_par_err);
    end
    send(8'h41, 1'b1, 1'b0);
    send(8'h42, 1'b0, 1'b0);
    send(8'h43, 1'b0, 1'b0);
    send(8'h44, 1'b0, 1'b0);
    total++;
    if (frame_valid !== 1'b1 || frame_data !== 32'h44434241 || frame_par_err !== 1'b0) begin
      bad++;
      $display("FAIL parity_good got v=%b d=%h pe=%b expected v=1 d=44434241 pe=0",
               frame_valid, frame_data, frame_par_err);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_hunt_drop();
    test_premature_sof();
    test_back_to_back();
    test_sync_loss();
    test_async_reset();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
